// File: rtl/sram_resp_pkg.sv
// Shared types, widths and address decode helpers for the SRAM responder.
package sram_resp_pkg;

  localparam int          DATA_W            = 32;
  localparam int          WE_W              = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1c00_0000;

  // True when a byte address lands inside the word window starting at base.
  // The limit is computed in 33 bits so a very deep window cannot overflow it.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned depth_log2);
    logic [32:0] off;
    logic [32:0] limit;
    off   = {1'b0, addr - base};
    limit = 33'd4 << depth_log2;
    return (addr >= base) && (off < limit);
  endfunction

  // Word offset of a byte address from base; the byte lane bits are dropped.
  function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return {2'b00, off[31:2]};
  endfunction

endpackage

// File: rtl/sram_resp_mem.sv
// Single-port word array with byte write enables and a read-first registered
// output. Out-of-window reads return zero instead of array contents.
module sram_resp_mem
  import sram_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rd_en,
  input  logic                  rd_valid,
  input  logic [WE_W-1:0]       we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [0:(1 << DEPTH_LOG2) - 1];

  // Byte-lane writes; the array has no reset so preloaded images survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WE_W; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered read of the old word on every accepted access; holds otherwise.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= rd_valid ? mem[addr] : '0;
    end
  end

endmodule

// File: rtl/sram_resp.sv
// Responder for the core's SRAM-style bus: word window at BASE_ADDR, a loader
// port that shares the array write port, sticky range error and access counters.
module sram_resp
  import sram_resp_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 16,
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sram_en,
  input  logic [WE_W-1:0]   sram_we,
  input  logic [31:0]       sram_addr,
  input  logic [DATA_W-1:0] sram_wdata,
  output logic [DATA_W-1:0] sram_rdata,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              err_oob,
  output logic [31:0]       err_addr,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt
);

  logic                  acc;
  logic                  prim_in;
  logic [31:0]           prim_off;
  logic                  ld_fire;
  logic                  ld_in;
  logic [31:0]           ld_off;
  logic [WE_W-1:0]       mem_we;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  unused_off_bits;

  assign acc      = resetn & sram_en;
  assign prim_in  = addr_in_range(sram_addr, BASE_ADDR, DEPTH_LOG2);
  assign prim_off = word_offset(sram_addr, BASE_ADDR);
  assign ld_ready = ~resetn | ~sram_en;
  assign ld_fire  = ld_valid & ld_ready;
  assign ld_in    = addr_in_range(ld_addr, BASE_ADDR, DEPTH_LOG2);
  assign ld_off   = word_offset(ld_addr, BASE_ADDR);

  // High offset bits only matter through the range check.
  assign unused_off_bits = &{1'b0, prim_off[31:DEPTH_LOG2], ld_off[31:DEPTH_LOG2]};

  // The primary port owns the single array port whenever it is active; the
  // loader only gets it on idle or reset cycles. Out-of-window writes are dropped.
  always_comb begin
    mem_we    = '0;
    mem_addr  = prim_off[DEPTH_LOG2-1:0];
    mem_wdata = sram_wdata;
    if (acc) begin
      mem_we = prim_in ? sram_we : '0;
    end else begin
      mem_addr  = ld_off[DEPTH_LOG2-1:0];
      mem_wdata = ld_data;
      mem_we    = (ld_fire && ld_in) ? {WE_W{1'b1}} : '0;
    end
  end

  sram_resp_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .resetn  (resetn),
    .rd_en   (acc),
    .rd_valid(prim_in),
    .we      (mem_we),
    .addr    (mem_addr),
    .wdata   (mem_wdata),
    .rdata   (sram_rdata)
  );

  // Sticky capture of the first out-of-window access plus read/write counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_oob  <= 1'b0;
      err_addr <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
    end else if (acc) begin
      if (!prim_in && !err_oob) begin
        err_oob  <= 1'b1;
        err_addr <= sram_addr;
      end
      if (sram_we == '0) begin
        rd_cnt <= rd_cnt + 32'd1;
      end else begin
        wr_cnt <= wr_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_sram_resp.sv
// Directed bench for sram_resp: preload under reset, read-first byte writes,
// window boundaries, loader arbitration, reset mid-operation and counter wrap.
module tb_sram_resp;

  logic        clk;
  logic        resetn;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        err_oob;
  logic [31:0] err_addr;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int checks   = 0;
  int failures = 0;

  sram_resp dut (
    .clk       (clk),
    .resetn    (resetn),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .err_oob   (err_oob),
    .err_addr  (err_addr),
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; sram_en = 1'b1; sram_we = 4'h0; sram_addr = 32'h1c00_0000;
    ld_valid = 1'b1; ld_addr = 32'h1c00_0000; ld_data = 32'h0280_0c0c;
    #1;
    checks++;
    if (ld_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ld_ready0 got=%b exp=1", ld_ready); end
    tick();
    ld_addr = 32'h1c00_0004; ld_data = 32'h0280_1c0c;
    #1;
    checks++;
    if (ld_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ld_ready1 got=%b exp=1", ld_ready); end
    tick();
    ld_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (sram_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata got=%h exp=00000000", sram_rdata); end
    checks++;
    if (rd_cnt !== 32'h0 || wr_cnt !== 32'h0) begin failures++; $display("[TB] FAIL reset_cnt got=%h/%h exp=0/0", rd_cnt, wr_cnt); end
    checks++;
    if (err_oob !== 1'b0 || err_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_err got=%b/%h exp=0/0", err_oob, err_addr); end
  endtask

  task automatic test_preload_read();
    resetn = 1'b1; sram_en = 1'b1; sram_we = 4'h0; sram_addr = 32'h1c00_0000;
    tick();
    checks++;
    if (sram_rdata !== 32'h0280_0c0c) begin failures++; $display("[TB] FAIL boot_rd0 got=%h exp=02800c0c", sram_rdata); end
    sram_addr = 32'h1c00_0004;
    tick();
    checks++;
    if (sram_rdata !== 32'h0280_1c0c) begin failures++; $display("[TB] FAIL boot_rd1 got=%h exp=02801c0c", sram_rdata); end
    sram_en = 1'b0;
    tick();
    checks++;
    if (sram_rdata !== 32'h0280_1c0c) begin failures++; $display("[TB] FAIL boot_hold got=%h exp=02801c0c", sram_rdata); end
    checks++;
    if (rd_cnt !== 32'd2 || err_oob !== 1'b0) begin failures++; $display("[TB] FAIL boot_cnt got=%0d/%b exp=2/0", rd_cnt, err_oob); end
  endtask

  task automatic test_byte_write();
    ld_valid = 1'b1; ld_addr = 32'h1c00_0010; ld_data = 32'h1122_3344;
    tick();
    ld_valid = 1'b0;
    sram_en = 1'b1; sram_we = 4'b0101; sram_addr = 32'h1c00_0010; sram_wdata = 32'haabb_ccdd;
    tick();
    checks++;
    if (sram_rdata !== 32'h1122_3344) begin failures++; $display("[TB] FAIL write_read_first got=%h exp=11223344", sram_rdata); end
    sram_we = 4'h0;
    tick();
    checks++;
    if (sram_rdata !== 32'h11bb_33dd) begin failures++; $display("[TB] FAIL write_merge got=%h exp=11bb33dd", sram_rdata); end
    sram_en = 1'b0;
    tick();
    checks++;
    if (wr_cnt !== 32'd1 || rd_cnt !== 32'd3) begin failures++; $display("[TB] FAIL write_cnt got=%0d/%0d exp=1/3", wr_cnt, rd_cnt); end
  endtask

  task automatic test_bounds();
    sram_en = 1'b1; sram_we = 4'h0; sram_addr = 32'h1bff_fffc;
    tick();
    checks++;
    if (sram_rdata !== 32'h0) begin failures++; $display("[TB] FAIL oob_low_rdata got=%h exp=00000000", sram_rdata); end
    checks++;
    if (err_oob !== 1'b1 || err_addr !== 32'h1bff_fffc) begin failures++; $display("[TB] FAIL oob_low_err got=%b/%h exp=1/1bfffffc", err_oob, err_addr); end
    sram_addr = 32'h1c04_0000;
    tick();
    checks++;
    if (sram_rdata !== 32'h0) begin failures++; $display("[TB] FAIL oob_high_rdata got=%h exp=00000000", sram_rdata); end
    checks++;
    if (err_addr !== 32'h1bff_fffc || rd_cnt !== 32'd5) begin failures++; $display("[TB] FAIL oob_sticky got=%h/%0d exp=1bfffffc/5", err_addr, rd_cnt); end
    // This write would alias word 0 if the range check were missing.
    sram_we = 4'hf; sram_wdata = 32'hdead_beef;
    tick();
    sram_addr = 32'h1c03_fffc; sram_wdata = 32'h5a5a_0001;
    tick();
    sram_we = 4'h0;
    tick();
    checks++;
    if (sram_rdata !== 32'h5a5a_0001) begin failures++; $display("[TB] FAIL top_word got=%h exp=5a5a0001", sram_rdata); end
    sram_addr = 32'h1c00_0000;
    tick();
    checks++;
    if (sram_rdata !== 32'h0280_0c0c) begin failures++; $display("[TB] FAIL oob_write_dropped got=%h exp=02800c0c", sram_rdata); end
    sram_en = 1'b0;
    tick();
    checks++;
    if (wr_cnt !== 32'd3 || rd_cnt !== 32'd7) begin failures++; $display("[TB] FAIL oob_cnt got=%0d/%0d exp=3/7", wr_cnt, rd_cnt); end
  endtask

  task automatic test_loader_stall();
    ld_valid = 1'b1; ld_addr = 32'h1c00_0024; ld_data = 32'h55aa_55aa;
    tick();
    sram_en = 1'b1; sram_we = 4'h0; sram_addr = 32'h1c00_0004;
    ld_addr = 32'h1c00_0024; ld_data = 32'h0bad_0001;
    #1;
    checks++;
    if (ld_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_ready0 got=%b exp=0", ld_ready); end
    tick();
    ld_data = 32'h0bad_0002;
    #1;
    checks++;
    if (ld_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_ready1 got=%b exp=0", ld_ready); end
    tick();
    sram_en = 1'b0; ld_addr = 32'h1c00_0020; ld_data = 32'hcafe_f00d;
    #1;
    checks++;
    if (ld_ready !== 1'b1) begin failures++; $display("[TB] FAIL stall_ready2 got=%b exp=1", ld_ready); end
    tick();
    ld_valid = 1'b0;
    sram_en = 1'b1; sram_addr = 32'h1c00_0020;
    tick();
    checks++;
    if (sram_rdata !== 32'hcafe_f00d) begin failures++; $display("[TB] FAIL stall_commit got=%h exp=cafef00d", sram_rdata); end
    sram_addr = 32'h1c00_0024;
    tick();
    checks++;
    if (sram_rdata !== 32'h55aa_55aa) begin failures++; $display("[TB] FAIL stall_no_early got=%h exp=55aa55aa", sram_rdata); end
    sram_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_op();
    sram_en = 1'b1; sram_we = 4'h0; sram_addr = 32'h1c00_0000;
    tick();
    sram_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (sram_rdata !== 32'h0280_0c0c) begin failures++; $display("[TB] FAIL idle_hold%0d got=%h exp=02800c0c", i, sram_rdata); end
    end
    resetn = 1'b0; sram_en = 1'b1; sram_we = 4'hf; sram_wdata = 32'hffff_ffff;
    tick();
    checks++;
    if (sram_rdata !== 32'h0) begin failures++; $display("[TB] FAIL mid_reset_rdata got=%h exp=00000000", sram_rdata); end
    checks++;
    if (rd_cnt !== 32'h0 || wr_cnt !== 32'h0 || err_oob !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_state got=%h/%h/%b exp=0/0/0", rd_cnt, wr_cnt, err_oob); end
    resetn = 1'b1; sram_we = 4'h0;
    tick();
    checks++;
    if (sram_rdata !== 32'h0280_0c0c) begin failures++; $display("[TB] FAIL mem_survives got=%h exp=02800c0c", sram_rdata); end
    sram_en = 1'b0;
    tick();
  endtask

  task automatic test_counter_wrap();
    force dut.wr_cnt = 32'hffff_ffff;
    #1;
    release dut.wr_cnt;
    #1;
    checks++;
    if (wr_cnt !== 32'hffff_ffff) begin failures++; $display("[TB] FAIL wrap_preset got=%h exp=ffffffff", wr_cnt); end
    sram_en = 1'b1; sram_we = 4'h1; sram_addr = 32'h1c00_0030; sram_wdata = 32'h0000_0077;
    tick();
    sram_en = 1'b0; sram_we = 4'h0;
    checks++;
    if (wr_cnt !== 32'h0) begin failures++; $display("[TB] FAIL wrap got=%h exp=00000000", wr_cnt); end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    resetn = 1'b0; sram_en = 1'b0; sram_we = 4'h0; sram_addr = 32'h0; sram_wdata = 32'h0;
    ld_valid = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
    @(negedge clk);
    $display("[TB] starting sram_resp bench");
    test_reset();
    test_preload_read();
    test_byte_write();
    test_bounds();
    test_loader_stall();
    test_reset_mid_op();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_resp.md
Name: sram_resp

Overview:
Responder end of the synchronous SRAM-style instruction/data bus (en, byte-we, addr, wdata → rdata one cycle later) that the pipeline front end drives.
- Backs the bus with a word-addressed memory window at BASE_ADDR.
- Read-first write semantics.
- Secondary loader port so a bench can preload program images, including while the core is held in reset.
- Sticky out-of-range error capture and access counters for debug and verification.

Parameters:
DEPTH_LOG2, 16, log2 of memory depth in 32-bit words (default 256 KB window)
BASE_ADDR, 32'h1c00_0000, byte address of word 0

Ports:
clk  input  1  clock
resetn  input  1  reset, synchronous, active-low
sram_en  input  1  access request this cycle
sram_we  input  4  byte write enables; 0 = read
sram_addr  input  32  byte address
sram_wdata  input  32  write data
sram_rdata  output  32  read data, valid the cycle after an accepted access
ld_valid  input  1  loader write request
ld_ready  output  1  loader accepted this cycle when ld_valid & ld_ready
ld_addr  input  32  loader byte address
ld_data  input  32  loader full-word data
err_oob  output  1  sticky: a primary access fell outside the window
err_addr  output  32  address of the first out-of-range primary access
rd_cnt  output  32  primary read accesses since reset
wr_cnt  output  32  primary write accesses since reset

Behaviour:
- Clock is clk; reset is resetn, synchronous, active-low.
- Address decode:
  - off = addr - BASE_ADDR, 32-bit wrap arithmetic.
  - In range iff addr >= BASE_ADDR and off < 4*2^DEPTH_LOG2.
  - idx = off[DEPTH_LOG2+1:2]; addr[1:0] is ignored.
- Primary access: accepted at a rising edge when resetn=1 and sram_en=1.
  - Read (we=0): sram_rdata at the next edge = mem[idx], or 32'h0 if out of range.
  - Write (we≠0): byte lane i of mem[idx] takes sram_wdata[8i+7:8i] when we[i]=1. Other lanes are unchanged.
  - A write also updates sram_rdata, with the OLD word (read-first); 0 if out of range.
  - An out-of-range write is dropped. Memory is not modified.
  - When sram_en=0, sram_rdata holds its last value.
  - Back-to-back accesses have no bubbles: one access per cycle, latency exactly 1.
- Loader:
  - ld_ready = ~resetn | ~sram_en (combinational). The primary port always wins; the loader stalls while the core accesses.
  - An accepted loader write stores all 4 bytes of ld_data at idx(ld_addr).
  - Out-of-range loader writes are dropped silently: no error flag, no counter update.
  - The loader is fully functional during reset. While resetn=0, the primary port is ignored entirely.
- Error capture:
  - When an out-of-range primary access is accepted and err_oob=0: set err_oob=1 and latch err_addr=sram_addr.
  - Later out-of-range accesses do not change err_addr.
  - Both are cleared only by reset.
- Counters:
  - rd_cnt += 1 per accepted primary read; wr_cnt += 1 per accepted primary write.
  - Out-of-range accesses are counted.
  - Counters wrap modulo 2^32.
- Reset values: sram_rdata=0, err_oob=0, err_addr=0, rd_cnt=0, wr_cnt=0. Memory contents are NOT cleared; they survive reset, so a preload done before or during reset persists.
- Reset mid-operation:
  - A request presented in the same cycle as resetn=0 is discarded, and sram_rdata becomes 0.
  - The first access is the one presented in the first cycle with resetn=1. For the front end this is fetch address 0x1c000000, whose data appears on sram_rdata one cycle later.
- Same-cycle write and loader: impossible by construction, since ld_ready=0 whenever sram_en=1 outside reset.

Decomposition:
- Shared package (e.g. sram_pkg): DATA_W=32, WE_W=4, default BASE_ADDR, and a function for in-range/index decode that the loader and the primary path share.
- One natural sub-module: sram_resp_mem.
  - Single-port 2^DEPTH_LOG2 x 32 array with byte write enables and read-first registered output.
  - Its write port is muxed between the primary port and the loader.
- Error and counter logic stay in the top.

Test Plan:
1. Hold resetn=0 for 5 cycles; load 0x02800c0c@0x1c000000 and 0x02801c0c@0x1c000004 via the loader (ld_ready=1 both cycles) → after reset, reads of 0x1c000000 and 0x1c000004 on consecutive cycles give rdata 0x02800c0c then 0x02801c0c, one cycle each. Then rd_cnt=2, err_oob=0.
2. Preload 0x11223344@0x1c000010 → write we=4'b0101, wdata=0xaabbccdd → rdata next cycle=0x11223344 (read-first). A following read returns 0x11bb33dd; wr_cnt=1.
3. Read 0x1bfffffc, then 0x1c040000 (DEPTH_LOG2=16) → rdata=0 for both, err_oob=1, err_addr=0x1bfffffc (unchanged by the second access), rd_cnt=2.
4. ld_valid=1 held while sram_en toggles 1,1,0 → ld_ready=0,0,1; the load commits only in the third cycle. A read of that word afterwards returns ld_data.
5. Read 0x1c000000 (rdata=X1), then sram_en=0 for 3 cycles → rdata stays X1. Assert resetn=0 with sram_en=1 → rdata=0, counters=0, err_oob=0; memory word is still X1 on the next read after reset.
6. Force wr_cnt near wrap via 2^32 writes, or run a reduced-width build → 0xffffffff + 1 = 0.
